// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter sharing one UART TX FIFO write port.
// Each granted packet is prefixed by a one-byte header {4'hA, source id}.
module uart_tx_arbiter #(
  parameter int N_SRC   = 4,
  parameter int MAX_LEN = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_SRC-1:0]   src_valid,
  input  logic [8*N_SRC-1:0] src_data,
  input  logic [N_SRC-1:0]   src_last,
  output logic [N_SRC-1:0]   src_ready,
  output logic [7:0]         fifo_data,
  output logic               fifo_write_enable,
  input  logic               fifo_full,
  input  logic               fifo_almost_full,
  output logic               busy,
  output logic [3:0]         grant_id,
  output logic               overlong
);

  localparam int               PTR_W     = $clog2(N_SRC);
  localparam int               PW1       = PTR_W + 1;
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(N_SRC - 1);
  localparam logic [PW1-1:0]   N_SRC_W   = PW1'(N_SRC);
  localparam logic [16:0]      MAX_LEN_W = 17'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } state_t;

  state_t           state_r;
  logic [3:0]       grant_id_r;
  logic [PTR_W-1:0] rr_ptr_r;
  logic [15:0]      len_cnt_r;
  logic             overlong_r;

  logic [PTR_W-1:0] g_s;
  logic [PTR_W-1:0] winner_s;
  logic             win_s;
  logic [PW1-1:0]   idx_s;
  logic [PTR_W-1:0] cand_s;
  logic             hit_s;
  logic [7:0]       sel_data_s;
  logic             sel_valid_s;
  logic             sel_last_s;
  logic             xfer_s;
  logic             hdr_wr_s;
  logic [PTR_W-1:0] next_ptr_s;
  logic             at_max_s;

  assign g_s        = grant_id_r[PTR_W-1:0];
  assign xfer_s     = (state_r == DATA) & sel_valid_s & ~fifo_full;
  assign hdr_wr_s   = (state_r == HEADER) & ~fifo_full;
  assign next_ptr_s = (g_s == LAST_IDX) ? {PTR_W{1'b0}} : (g_s + PTR_W'(1));
  assign at_max_s   = (({1'b0, len_cnt_r} + 17'd1) == MAX_LEN_W);

  // Round-robin search: first valid source at or above rr_ptr, wrapping modulo N_SRC
  always_comb begin
    win_s    = 1'b0;
    winner_s = {PTR_W{1'b0}};
    idx_s    = {PW1{1'b0}};
    cand_s   = {PTR_W{1'b0}};
    hit_s    = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      idx_s    = {1'b0, rr_ptr_r} + PW1'(k);
      idx_s    = (idx_s >= N_SRC_W) ? (idx_s - N_SRC_W) : idx_s;
      cand_s   = idx_s[PTR_W-1:0];
      hit_s    = src_valid[cand_s] & ~win_s;
      winner_s = hit_s ? cand_s : winner_s;
      win_s    = win_s | hit_s;
    end
  end

  // Select the granted source's byte, valid and last flags
  always_comb begin
    sel_data_s  = 8'h00;
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      sel_data_s  = sel_data_s  | ({8{g_s == PTR_W'(k)}} & src_data[8*k +: 8]);
      sel_valid_s = sel_valid_s | ((g_s == PTR_W'(k)) & src_valid[k]);
      sel_last_s  = sel_last_s  | ((g_s == PTR_W'(k)) & src_last[k]);
    end
  end

  // Datapath outputs decode from state; IDLE drives everything to zero
  always_comb begin
    src_ready         = {N_SRC{1'b0}};
    fifo_data         = 8'h00;
    fifo_write_enable = 1'b0;
    case (state_r)
      HEADER: begin
        fifo_data         = {4'hA, grant_id_r};
        fifo_write_enable = hdr_wr_s;
      end
      DATA: begin
        src_ready[g_s]    = ~fifo_full;
        fifo_data         = sel_data_s;
        fifo_write_enable = xfer_s;
      end
      default: begin
        src_ready         = {N_SRC{1'b0}};
        fifo_data         = 8'h00;
        fifo_write_enable = 1'b0;
      end
    endcase
  end

  assign busy     = (state_r != IDLE);
  assign grant_id = grant_id_r;
  assign overlong = overlong_r;

  // Packet FSM: grant, header, data; release on last byte or at MAX_LEN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      grant_id_r <= 4'd0;
      rr_ptr_r   <= {PTR_W{1'b0}};
      len_cnt_r  <= 16'd0;
      overlong_r <= 1'b0;
    end else begin
      overlong_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (win_s && !fifo_almost_full) begin
            grant_id_r <= 4'(winner_s);
            len_cnt_r  <= 16'd0;
            state_r    <= HEADER;
          end
        end
        HEADER: begin
          if (hdr_wr_s) begin
            state_r <= DATA;
          end
        end
        DATA: begin
          if (xfer_s) begin
            len_cnt_r <= len_cnt_r + 16'd1;
            if (sel_last_s) begin
              state_r  <= IDLE;
              rr_ptr_r <= next_ptr_s;
            end else if (at_max_s) begin
              // forced release; the rest of the packet waits for a new grant
              state_r    <= IDLE;
              rr_ptr_r   <= next_ptr_s;
              overlong_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
